// File: rtl/circle_pkg.sv
// Shared types and screen constants for the midpoint circle plotter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package circle_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        PLOT = 2'd2,
        DONE = 2'd3
    } state_t;

    // Signed so that centre-minus-offset goes negative instead of wrapping.
    typedef logic signed [9:0]  coord_t;
    typedef logic signed [11:0] crit_t;

endpackage

// File: rtl/circle_octant_pt.sv
// Maps (centre, offsets, octant index) to one circle pixel and clips it to the screen.
// Latency: combinational.
// Backpressure: none; evaluated every cycle.
module circle_octant_pt
    import circle_pkg::*;
(
    input  coord_t     cx,
    input  coord_t     cy,
    input  coord_t     ox,
    input  coord_t     oy,
    input  logic [2:0] k,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic       on_screen
);

    coord_t px;
    coord_t py;

    // Octant k selects which of the eight symmetric points is produced.
    always_comb begin
        px = cx;
        py = cy;
        case (k)
            3'd0: begin px = cx + ox; py = cy + oy; end
            3'd1: begin px = cx + oy; py = cy + ox; end
            3'd2: begin px = cx - ox; py = cy + oy; end
            3'd3: begin px = cx - oy; py = cy + ox; end
            3'd4: begin px = cx - ox; py = cy - oy; end
            3'd5: begin px = cx - oy; py = cy - ox; end
            3'd6: begin px = cx + ox; py = cy - oy; end
            default: begin px = cx + oy; py = cy - ox; end
        endcase
    end

    // Clip against the full signed range; off-screen points report zero coordinates.
    always_comb begin
        on_screen = (px >= coord_t'(0)) && (px < coord_t'(SCREEN_W)) &&
                    (py >= coord_t'(0)) && (py < coord_t'(SCREEN_H));
        x = on_screen ? px[7:0] : 8'd0;
        y = on_screen ? py[6:0] : 7'd0;
    end

endmodule

// File: rtl/circle_plotter.sv
// Midpoint circle outline generator: one octant pixel per clock into the VGA adapter.
// Latency: done rises 8N+2 edges after start is sampled (N = midpoint iterations).
// Backpressure: none; the adapter must accept one pixel per cycle.
module circle_plotter
    import circle_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] centre_x,
    input  logic [6:0] centre_y,
    input  logic [7:0] radius,
    input  logic [2:0] colour,
    output logic       done,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);

    state_t     state_q, state_d;
    logic [2:0] k_q, k_d;
    coord_t     cx_q, cx_d, cy_q, cy_d;
    coord_t     ox_q, ox_d, oy_q, oy_d;
    crit_t      crit_q, crit_d;
    logic [2:0] col_q, col_d;
    logic       done_q, done_d;
    logic       plot_q, plot_d;
    logic [7:0] vga_x_q, vga_x_d;
    logic [6:0] vga_y_q, vga_y_d;
    logic [2:0] vga_col_q, vga_col_d;

    coord_t     oy_n, ox_n;
    logic [7:0] pt_x;
    logic [6:0] pt_y;
    logic       pt_on;

    // The pixel is computed from next-state values so the registered outputs
    // carry the pixel during the very PLOT cycle that owns it.
    circle_octant_pt u_pt (
        .cx        (cx_d),
        .cy        (cy_d),
        .ox        (ox_d),
        .oy        (oy_d),
        .k         (k_d),
        .x         (pt_x),
        .y         (pt_y),
        .on_screen (pt_on)
    );

    // Next-state, midpoint update and output computation.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        crit_d  = crit_q;
        col_d   = col_q;
        oy_n    = oy_q + coord_t'(1);
        ox_n    = ox_q;

        case (state_q)
            IDLE: begin
                if (start) state_d = INIT;
            end
            INIT: begin
                cx_d    = coord_t'({2'b00, centre_x});
                cy_d    = coord_t'({3'b000, centre_y});
                ox_d    = coord_t'({2'b00, radius});
                oy_d    = coord_t'(0);
                crit_d  = crit_t'(1) - crit_t'({4'b0000, radius});
                col_d   = colour;
                k_d     = 3'd0;
                state_d = PLOT;
            end
            PLOT: begin
                k_d = k_q + 3'd1;
                if (k_q == 3'd7) begin
                    if (crit_q <= crit_t'(0)) begin
                        crit_d = crit_q + crit_t'(oy_n) + crit_t'(oy_n) + crit_t'(1);
                    end else begin
                        ox_n   = ox_q - coord_t'(1);
                        crit_d = crit_q + crit_t'(oy_n - ox_n) + crit_t'(oy_n - ox_n) + crit_t'(1);
                    end
                    ox_d = ox_n;
                    oy_d = oy_n;
                    if (oy_n > ox_n) state_d = DONE;
                end
            end
            default: begin
                if (!start) state_d = IDLE;
            end
        endcase

        done_d    = (state_d == DONE);
        plot_d    = (state_d == PLOT) && pt_on;
        vga_x_d   = plot_d ? pt_x  : 8'd0;
        vga_y_d   = plot_d ? pt_y  : 7'd0;
        vga_col_d = plot_d ? col_d : 3'd0;
    end

    // State and datapath registers; reset aborts any draw in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            k_q       <= 3'd0;
            cx_q      <= '0;
            cy_q      <= '0;
            ox_q      <= '0;
            oy_q      <= '0;
            crit_q    <= '0;
            col_q     <= 3'd0;
            done_q    <= 1'b0;
            plot_q    <= 1'b0;
            vga_x_q   <= 8'd0;
            vga_y_q   <= 7'd0;
            vga_col_q <= 3'd0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            ox_q      <= ox_d;
            oy_q      <= oy_d;
            crit_q    <= crit_d;
            col_q     <= col_d;
            done_q    <= done_d;
            plot_q    <= plot_d;
            vga_x_q   <= vga_x_d;
            vga_y_q   <= vga_y_d;
            vga_col_q <= vga_col_d;
        end
    end

    assign done       = done_q;
    assign vga_plot   = plot_q;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_col_q;

endmodule

// File: tb/tb_circle_plotter.sv
// Self-checking bench: directed and random circles against a midpoint reference model.
// Latency: checks done timing at 8N+2 edges after start is sampled.
// Backpressure: n/a.
module tb_circle_plotter;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] centre_x;
    logic [6:0] centre_y;
    logic [7:0] radius;
    logic [2:0] colour;
    logic       done;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    int errors = 0;
    int checks = 0;

    // Expected per-cycle pixel stream from the reference model.
    int eq_x[$];
    int eq_y[$];
    bit eq_on[$];

    // Observations collected during the last run.
    int pulses;
    int wrapped;
    bit seen[0:159][0:119];

    always #5 clk = ~clk;

    circle_plotter dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .centre_x   (centre_x),
        .centre_y   (centre_y),
        .radius     (radius),
        .colour     (colour),
        .done       (done),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Midpoint circle over plain integers; every octant point in drawing order,
    // marked on-screen or clipped.
    function automatic void build(input int cx, input int cy, input int r);
        int ox, oy, d;
        int px[8];
        int py[8];
        eq_x.delete();
        eq_y.delete();
        eq_on.delete();
        ox = r;
        oy = 0;
        d  = 1 - r;
        do begin
            px = '{cx + ox, cx + oy, cx - ox, cx - oy, cx - ox, cx - oy, cx + ox, cx + oy};
            py = '{cy + oy, cy + ox, cy + oy, cy + ox, cy - oy, cy - ox, cy - oy, cy - ox};
            for (int k = 0; k < 8; k++) begin
                eq_x.push_back(px[k]);
                eq_y.push_back(py[k]);
                eq_on.push_back(px[k] >= 0 && px[k] < 160 && py[k] >= 0 && py[k] < 120);
            end
            oy++;
            if (d <= 0) begin
                d += 2 * oy + 1;
            end else begin
                ox--;
                d += 2 * (oy - ox) + 1;
            end
        end while (oy <= ox);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Draws one circle and checks every PLOT cycle plus the done handshake.
    // disturb != 0 changes centre_x/radius and re-pulses start mid-draw.
    task automatic run_circle(input int cx, input int cy, input int r,
                              input logic [2:0] col, input bit disturb);
        int n;
        build(cx, cy, r);
        n       = eq_x.size();
        pulses  = 0;
        wrapped = 0;
        for (int i = 0; i < 160; i++)
            for (int j = 0; j < 120; j++)
                seen[i][j] = 1'b0;
        centre_x = 8'(cx);
        centre_y = 7'(cy);
        radius   = 8'(r);
        colour   = col;
        start    = 1'b1;
        tick();                 // edge 1: start sampled
        tick();                 // edge 2: first PLOT cycle
        for (int i = 0; i < n; i++) begin
            check("plot",   {31'd0, vga_plot},  {31'd0, eq_on[i]});
            check("x",      {24'd0, vga_x},     eq_on[i] ? eq_x[i] : 0);
            check("y",      {25'd0, vga_y},     eq_on[i] ? eq_y[i] : 0);
            check("colour", {29'd0, vga_colour}, eq_on[i] ? {29'd0, col} : 0);
            check("busy_done", {31'd0, done}, 0);
            if (vga_plot) begin
                pulses++;
                if (vga_x >= 8'd160 || vga_y >= 7'd120) wrapped++;
                else seen[vga_x][vga_y] = 1'b1;
            end
            if (disturb && i == 5) begin
                centre_x = ~centre_x;
                radius   = radius + 8'd7;
                colour   = ~colour;
                start    = 1'b0;
            end
            if (disturb && i == 9) start = 1'b1;
            tick();
        end
        // Now at edge 8N+2.
        check("done_rise", {31'd0, done}, 1);
        check("done_plot", {31'd0, vga_plot}, 0);
        start = 1'b1;
        tick();
        tick();
        check("done_hold", {31'd0, done}, 1);
        check("no_redraw", {31'd0, vga_plot}, 0);
        start = 1'b0;
        tick();
        check("done_clear", {31'd0, done}, 0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        centre_x = 8'd0;
        centre_y = 7'd0;
        radius   = 8'd0;
        colour   = 3'd0;
        tick();
        tick();
        check("rst_done",   {31'd0, done},       0);
        check("rst_plot",   {31'd0, vga_plot},   0);
        check("rst_x",      {24'd0, vga_x},      0);
        check("rst_y",      {25'd0, vga_y},      0);
        check("rst_colour", {29'd0, vga_colour}, 0);
        rst = 1'b0;
        tick();

        // radius 0: centre plotted 8 times, done on the 10th edge.
        run_circle(80, 60, 0, 3'b010, 1'b0);
        check("r0_pulses", pulses, 8);
        check("r0_centre", {31'd0, seen[80][60]}, 1);

        // radius 1: two iterations, 16 pulses.
        run_circle(80, 60, 1, 3'b101, 1'b0);
        check("r1_pulses", pulses, 16);
        check("r1_diag", {31'd0, seen[81][61]}, 1);

        // Corner circle: clipped, no wrapped coordinates.
        run_circle(0, 0, 10, 3'b111, 1'b0);
        check("c10_0",   {31'd0, seen[10][0]}, 1);
        check("c0_10",   {31'd0, seen[0][10]}, 1);
        check("c7_7",    {31'd0, seen[7][7]},  1);
        check("c_wrap",  wrapped, 0);

        // Radius 255: everything clipped, done timing unchanged.
        run_circle(80, 60, 255, 3'b001, 1'b0);
        check("r255_pulses", pulses, 0);

        // Reset mid-draw on radius 40.
        build(80, 60, 40);
        centre_x = 8'd80;
        centre_y = 7'd60;
        radius   = 8'd40;
        colour   = 3'b110;
        start    = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 13; i++) begin
            check("pre_rst_x", {24'd0, vga_x}, eq_on[i] ? eq_x[i] : 0);
            tick();
        end
        rst   = 1'b1;
        start = 1'b0;
        tick();
        check("abort_plot", {31'd0, vga_plot}, 0);
        check("abort_done", {31'd0, done},     0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort_idle", {31'd0, vga_plot}, 0);
        end
        run_circle(80, 60, 40, 3'b110, 1'b0);

        // Input changes and start re-pulse mid-draw are ignored.
        run_circle(70, 50, 30, 3'b011, 1'b1);

        // Random circles.
        for (int t = 0; t < 6; t++) begin
            run_circle($urandom_range(0, 159), $urandom_range(0, 119),
                       $urandom_range(0, 90), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
